// File: rtl/nco_ctrl_pkg.sv
// Shared types and default widths for the NCO sweep controller.
package nco_ctrl_pkg;

    localparam int ACC_W   = 32;
    localparam int CNT_W   = 16;
    localparam int DWELL_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    typedef struct packed {
        logic [ACC_W-1:0]   start_tune;
        logic [ACC_W-1:0]   step;
        logic [CNT_W-1:0]   n_steps;
        logic [DWELL_W-1:0] dwell;
    } sweep_cfg_t;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Sweep descriptor valid/ready channel between the register side and nco_sweep_ctrl.
interface nco_sweep_ctrl_if #(
    parameter int ACC_W   = 32,
    parameter int CNT_W   = 16,
    parameter int DWELL_W = 16
);
    import nco_ctrl_pkg::*;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [ACC_W-1:0]   start_tune;
    logic [ACC_W-1:0]   step;
    logic [CNT_W-1:0]   n_steps;
    logic [DWELL_W-1:0] dwell;

    modport master (
        output cfg_valid, start_tune, step, n_steps, dwell,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, start_tune, step, n_steps, dwell,
        output cfg_ready
    );

endinterface

// File: rtl/nco_sweep_ctrl_dwell_timer.sv
// Loadable down-counter; o_last flags the final cycle a tune is held.
module nco_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_load_val,
    output logic               o_last
);
    import nco_ctrl_pkg::*;

    logic [DWELL_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - DWELL_W'(1);
        end
    end

    assign o_last = (r_count == DWELL_W'(1));

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped-chirp scheduler driving basic_nco tune/ce from one accepted descriptor.
// Define NCO_SWEEP_TRI_EN for a triangular (up then down) sweep.
module nco_sweep_ctrl #(
    parameter int ACC_W   = 32,
    parameter int CNT_W   = 16,
    parameter int DWELL_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    nco_sweep_ctrl_if.slave   cfg,
    input  logic              i_abort,
    output logic [ACC_W-1:0]  o_tune,
    output logic              o_nco_ce,
    output logic              o_busy,
    output logic              o_done
);
    import nco_ctrl_pkg::*;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_DWELL = DWELL;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]         r_state;
    logic [ACC_W-1:0]   r_step;
    logic [CNT_W-1:0]   r_n_steps;
    logic [CNT_W-1:0]   r_steps_left;
    logic [DWELL_W-1:0] r_dwell;
    logic [ACC_W-1:0]   r_tune;
    logic               r_ce;
    logic               r_busy;
    logic               r_done;
`ifdef NCO_SWEEP_TRI_EN
    logic               r_down;
`endif

    logic               w_xfer;
    logic [DWELL_W-1:0] w_dwell_eff;
    logic               w_last;
    logic               w_more;
    logic               w_timer_load;
    logic [DWELL_W-1:0] w_timer_val;

    assign cfg.cfg_ready = (r_state == ST_IDLE) && !i_abort;
    assign w_xfer        = cfg.cfg_valid && cfg.cfg_ready;
    assign w_dwell_eff   = (cfg.dwell == '0) ? DWELL_W'(1) : cfg.dwell;

    // Another tune follows the current one (either leg still has steps).
`ifdef NCO_SWEEP_TRI_EN
    assign w_more = (r_steps_left != '0) || (!r_down && (r_n_steps != '0));
`else
    assign w_more = (r_steps_left != '0);
`endif

    assign w_timer_load = w_xfer ||
                          ((r_state == ST_DWELL) && w_last && w_more && !i_abort);
    assign w_timer_val  = (r_state == ST_IDLE) ? w_dwell_eff : r_dwell;

    nco_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (i_abort),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .o_last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_step       <= '0;
            r_n_steps    <= '0;
            r_steps_left <= '0;
            r_dwell      <= '0;
            r_tune       <= '0;
            r_ce         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef NCO_SWEEP_TRI_EN
            r_down       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_abort) begin
                        r_ce <= 1'b0;
                    end else if (w_xfer) begin
                        r_step       <= cfg.step;
                        r_n_steps    <= cfg.n_steps;
                        r_steps_left <= cfg.n_steps;
                        r_dwell      <= w_dwell_eff;
                        r_tune       <= cfg.start_tune;
                        r_ce         <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_DWELL;
`ifdef NCO_SWEEP_TRI_EN
                        r_down       <= 1'b0;
`endif
                    end
                end
                ST_DWELL: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_ce    <= 1'b0;
                    end else if (w_last) begin
                        if (r_steps_left != '0) begin
                            r_tune       <= r_tune + r_step;
                            r_steps_left <= r_steps_left - CNT_W'(1);
                        end
`ifdef NCO_SWEEP_TRI_EN
                        // Turnaround: the peak is not repeated, so step down immediately.
                        else if (!r_down && (r_n_steps != '0)) begin
                            r_step       <= -r_step;
                            r_tune       <= r_tune - r_step;
                            r_steps_left <= r_n_steps - CNT_W'(1);
                            r_down       <= 1'b1;
                        end
`endif
                        else begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (i_abort) begin
                        r_ce <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ce    <= 1'b0;
                end
            endcase
        end
    end

    assign o_tune   = r_tune;
    assign o_nco_ce = r_ce;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: descriptor table with a tune scoreboard,
// plus abort, abort-in-idle and mid-sweep reset sequences.
module tb_nco_sweep_ctrl;
    import nco_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] tune;
    logic        ce;
    logic        busy;
    logic        done;

    int nCompared   = 0;
    int nMismatched = 0;
    logic [31:0] expQ[$];

    always #5 clk = ~clk;

    nco_sweep_ctrl_if #(.ACC_W(32), .CNT_W(16), .DWELL_W(16)) cfgIf ();

    nco_sweep_ctrl #(
        .ACC_W   (32),
        .CNT_W   (16),
        .DWELL_W (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cfg      (cfgIf.slave),
        .i_abort  (abort),
        .o_tune   (tune),
        .o_nco_ce (ce),
        .o_busy   (busy),
        .o_done   (done)
    );

    typedef struct {
        string      name;
        sweep_cfg_t cfg;
        int         expBusy;
        logic [31:0] expFinal;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a descriptor at a negedge, wait (bounded) for ready, transfer, and
    // queue every tune expected on o_tune while busy.
    task automatic applyStimulus(input sweep_cfg_t c);
        int waitCycles = 0;
        int dEff;
        logic [31:0] t;
        cfgIf.cfg_valid  = 1'b1;
        cfgIf.start_tune = c.start_tune;
        cfgIf.step       = c.step;
        cfgIf.n_steps    = c.n_steps;
        cfgIf.dwell      = c.dwell;
        while (!cfgIf.cfg_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("cfg_ready_wait", {31'd0, cfgIf.cfg_ready}, 32'd1);
        @(posedge clk);
        dEff = (c.dwell == 16'd0) ? 1 : int'(c.dwell);
        for (int k = 0; k <= int'(c.n_steps); k++) begin
            t = c.start_tune + c.step * 32'(k);
            for (int d = 0; d < dEff; d++) expQ.push_back(t);
        end
`ifdef NCO_SWEEP_TRI_EN
        for (int k = int'(c.n_steps) - 1; k >= 0; k--) begin
            t = c.start_tune + c.step * 32'(k);
            for (int d = 0; d < dEff; d++) expQ.push_back(t);
        end
`endif
        @(negedge clk);
        cfgIf.cfg_valid = 1'b0;
    endtask

    task automatic drainAndCheck(input vec_t v);
        int busyCycles = 0;
        logic [31:0] exp;
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            checkOutput({v.name, " tune"}, tune, exp);
            checkOutput({v.name, " busy"}, {31'd0, busy}, 32'd1);
            if (busy) busyCycles++;
            @(negedge clk);
        end
        checkOutput({v.name, " done_pulse"}, {31'd0, done}, 32'd1);
        checkOutput({v.name, " busy_in_done"}, {31'd0, busy}, 32'd0);
        checkOutput({v.name, " ce_in_done"}, {31'd0, ce}, 32'd1);
        checkOutput({v.name, " final_tune"}, tune, v.expFinal);
        checkOutput({v.name, " busy_cycles"}, 32'(busyCycles), 32'(v.expBusy));
        @(negedge clk);
        checkOutput({v.name, " done_cleared"}, {31'd0, done}, 32'd0);
        checkOutput({v.name, " ready_after"}, {31'd0, cfgIf.cfg_ready}, 32'd1);
        checkOutput({v.name, " ce_idle_hold"}, {31'd0, ce}, 32'd1);
        checkOutput({v.name, " tune_idle_hold"}, tune, v.expFinal);
    endtask

    initial begin
        vec_t vecs[6];
        sweep_cfg_t c2;

        cfgIf.cfg_valid  = 1'b0;
        cfgIf.start_tune = '0;
        cfgIf.step       = '0;
        cfgIf.n_steps    = '0;
        cfgIf.dwell      = '0;

        vecs[0] = '{"t1_const",  '{32'd1677722,   32'd0,          16'd0, 16'd5}, 5, 32'd1677722};
        vecs[1] = '{"t2_ramp",   '{32'd1000,      32'd16,         16'd3, 16'd2}, 8, 32'd1048};
        vecs[2] = '{"t3_wrap",   '{32'hFFFF_FFF0, 32'd32,         16'd1, 16'd1}, 2, 32'h0000_0010};
        vecs[3] = '{"t3_dwell0", '{32'hFFFF_FFF0, 32'd32,         16'd1, 16'd0}, 2, 32'h0000_0010};
`ifdef NCO_SWEEP_TRI_EN
        vecs[4] = '{"t4_down",   '{32'd3,         32'hFFFF_FFFF,  16'd4, 16'd1}, 9, 32'd3};
        vecs[5] = '{"t6_tri",    '{32'd0,         32'd10,         16'd2, 16'd1}, 5, 32'd0};
`else
        vecs[4] = '{"t4_down",   '{32'd3,         32'hFFFF_FFFF,  16'd4, 16'd1}, 5, 32'hFFFF_FFFF};
        vecs[5] = '{"t6_tri",    '{32'd0,         32'd10,         16'd2, 16'd1}, 3, 32'd20};
`endif
        c2 = vecs[1].cfg;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst tune", tune, 32'd0);
        checkOutput("rst ce", {31'd0, ce}, 32'd0);
        checkOutput("rst busy", {31'd0, busy}, 32'd0);
        checkOutput("rst done", {31'd0, done}, 32'd0);
        checkOutput("rst ready", {31'd0, cfgIf.cfg_ready}, 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Back-to-back table: each descriptor offered on the first IDLE cycle
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].cfg);
            drainAndCheck(vecs[i]);
        end

        // Abort on the third busy cycle of the ramp, then abort+valid in IDLE
        applyStimulus(c2);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort pre tune", tune, 32'd1016);
        abort = 1'b1;
        checkOutput("abort ready_dwell", {31'd0, cfgIf.cfg_ready}, 32'd0);
        @(negedge clk);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort ce", {31'd0, ce}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        checkOutput("abort tune_hold", tune, 32'd1016);
        checkOutput("abort ready_idle", {31'd0, cfgIf.cfg_ready}, 32'd0);
        cfgIf.cfg_valid  = 1'b1;
        cfgIf.start_tune = 32'd555;
        @(negedge clk);
        checkOutput("abort_valid busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_valid ce", {31'd0, ce}, 32'd0);
        checkOutput("abort_valid tune", tune, 32'd1016);
        cfgIf.cfg_valid = 1'b0;
        abort = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("post_abort done", {31'd0, done}, 32'd0);
        checkOutput("post_abort busy", {31'd0, busy}, 32'd0);
        checkOutput("post_abort ready", {31'd0, cfgIf.cfg_ready}, 32'd1);

        // Reset mid-sweep
        applyStimulus(c2);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst tune", tune, 32'd0);
        checkOutput("midrst ce", {31'd0, ce}, 32'd0);
        checkOutput("midrst busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        expQ.delete();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        nMismatched++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
